// File: rtl/ser_tx.sv
// Serial frame transmitter: start bit (0), DATA_W data bits LSB first, stop bit (1),
// each bit held for CLKS_PER_BIT cycles. Words are accepted over a valid/ready handshake.
module ser_tx #(
  parameter int unsigned DATA_W       = 8,
  parameter int unsigned CLKS_PER_BIT = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] data_in,
  input  logic              valid_in,
  output logic              ready_out,
  output logic              tx,
  output logic              busy
);

  localparam int unsigned CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int unsigned IDX_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_W - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t            state;
  logic [CNT_W-1:0]  cyc_cnt;
  logic [IDX_W-1:0]  bit_idx;
  logic [DATA_W-1:0] shift_reg;
  logic [DATA_W-1:0] shift_nxt;
  logic              bit_end;

  assign bit_end   = (cyc_cnt == CNT_LAST);
  assign shift_nxt = shift_reg >> 1;

  // tx is only ever loaded on a bit boundary, so it cannot change mid bit period.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cyc_cnt   <= '0;
      bit_idx   <= '0;
      shift_reg <= '0;
      tx        <= 1'b1;
      busy      <= 1'b0;
      ready_out <= 1'b1;
    end else begin
      if (state != IDLE) begin
        cyc_cnt <= bit_end ? '0 : cyc_cnt + CNT_W'(1);
      end
      case (state)
        IDLE: begin
          if (valid_in && ready_out) begin
            state     <= START;
            shift_reg <= data_in;
            cyc_cnt   <= '0;
            tx        <= 1'b0;
            busy      <= 1'b1;
            ready_out <= 1'b0;
          end
        end
        START: begin
          if (bit_end) begin
            state   <= DATA;
            bit_idx <= '0;
            tx      <= shift_reg[0];
          end
        end
        DATA: begin
          if (bit_end) begin
            shift_reg <= shift_nxt;
            if (bit_idx == IDX_LAST) begin
              state   <= STOP;
              bit_idx <= '0;
              tx      <= 1'b1;
            end else begin
              bit_idx <= bit_idx + IDX_W'(1);
              tx      <= shift_nxt[0];
            end
          end
        end
        STOP: begin
          if (bit_end) begin
            state     <= IDLE;
            busy      <= 1'b0;
            ready_out <= 1'b1;
          end
        end
        default: begin
          state     <= IDLE;
          tx        <= 1'b1;
          busy      <= 1'b0;
          ready_out <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ser_tx.sv
// Testbench for ser_tx: default instance (8 bits, 4 clocks/bit) and a corner instance
// (16 bits, 1 clock/bit), checked against a queue-of-line-levels reference model.
module tb_ser_tx;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  data_in;
  logic        valid_in;
  logic        ready_out, tx, busy;
  logic [15:0] data16;
  logic        valid16;
  logic        ready16, tx16, busy16;

  int n_checks = 0;
  int n_fail   = 0;
  int cycle    = 0;

  // Expected future line levels, one entry per clock cycle; empty means idle.
  bit q0[$];
  bit q1[$];

  typedef struct {
    logic [7:0] data;
    logic [9:0] frame;  // line level per bit period, index 0 first on the wire
  } vec_t;
  vec_t vecs[6];

  always #5 clk = ~clk;

  ser_tx #(.DATA_W(8), .CLKS_PER_BIT(4)) dut (
    .clk(clk), .rst(rst), .data_in(data_in), .valid_in(valid_in),
    .ready_out(ready_out), .tx(tx), .busy(busy)
  );

  ser_tx #(.DATA_W(16), .CLKS_PER_BIT(1)) dut16 (
    .clk(clk), .rst(rst), .data_in(data16), .valid_in(valid16),
    .ready_out(ready16), .tx(tx16), .busy(busy16)
  );

  function automatic void check(string name, logic act, logic exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b at cycle %0d", name, act, exp, cycle);
    end
  endfunction

  function automatic bit frame_bit(logic [15:0] d, int dw, int b);
    if (b == 0) return 1'b0;
    if (b == dw + 1) return 1'b1;
    return d[b-1];
  endfunction

  // One clock: advance the model with the inputs seen at the edge, then compare.
  task automatic step();
    @(posedge clk);
    if (rst) begin
      q0.delete();
      q1.delete();
    end else begin
      if (q0.size() > 0) void'(q0.pop_front());
      else if (valid_in)
        for (int b = 0; b < 10; b++) repeat (4) q0.push_back(frame_bit(16'(data_in), 8, b));
      if (q1.size() > 0) void'(q1.pop_front());
      else if (valid16)
        for (int b = 0; b < 18; b++) q1.push_back(frame_bit(data16, 16, b));
    end
    #1;
    cycle++;
    check("model_tx",      tx,        (q0.size() > 0) ? q0[0] : 1'b1);
    check("model_busy",    busy,      q0.size() > 0);
    check("model_ready",   ready_out, q0.size() == 0);
    check("model_tx16",    tx16,      (q1.size() > 0) ? q1[0] : 1'b1);
    check("model_busy16",  busy16,    q1.size() > 0);
    check("model_ready16", ready16,   q1.size() == 0);
  endtask

  task automatic idle_check(string name);
    check({name, "_tx"},    tx,        1'b1);
    check({name, "_busy"},  busy,      1'b0);
    check({name, "_ready"}, ready_out, 1'b1);
  endtask

  task automatic frame_check(string name, logic [9:0] f, int k);
    check({name, "_tx"},    tx,        f[k/4]);
    check({name, "_busy"},  busy,      1'b1);
    check({name, "_ready"}, ready_out, 1'b0);
  endtask

  // Accept one word with a single-cycle valid and check the whole 40-cycle frame.
  task automatic send_and_check(string name, logic [7:0] d, logic [9:0] f);
    data_in  = d;
    valid_in = 1'b1;
    step();
    valid_in = 1'b0;
    data_in  = 8'($urandom);
    for (int k = 0; k < 40; k++) begin
      if (k > 0) step();
      frame_check(name, f, k);
    end
    step();
    idle_check({name, "_end"});
  endtask

  initial begin
    vecs[0] = '{8'hA5, 10'h34A};
    vecs[1] = '{8'h00, 10'h200};
    vecs[2] = '{8'hFF, 10'h3FE};
    vecs[3] = '{8'h81, 10'h302};
    vecs[4] = '{8'h5A, 10'h2B4};
    vecs[5] = '{8'h3C, 10'h278};

    rst = 1'b1; valid_in = 1'b0; data_in = '0; valid16 = 1'b0; data16 = '0;
    repeat (3) step();
    idle_check("reset");
    rst = 1'b0;
    for (int i = 0; i < 20; i++) begin
      step();
      idle_check("idle");
    end

    for (int i = 0; i < 6; i++) send_and_check("table", vecs[i].data, vecs[i].frame);

    // Back-to-back with valid held: exactly one idle-high cycle between frames.
    data_in = 8'h00; valid_in = 1'b1;
    step();
    data_in = 8'hFF;
    for (int k = 0; k < 40; k++) begin
      if (k > 0) step();
      frame_check("b2b_first", 10'h200, k);
    end
    step();
    idle_check("b2b_gap");
    step();
    valid_in = 1'b0;
    for (int k = 0; k < 40; k++) begin
      if (k > 0) step();
      frame_check("b2b_second", 10'h3FE, k);
    end
    step();
    idle_check("b2b_end");

    // valid pulse mid-frame is ignored and spawns no extra frame.
    data_in = 8'h81; valid_in = 1'b1;
    step();
    valid_in = 1'b0;
    for (int k = 0; k < 40; k++) begin
      if (k > 0) step();
      frame_check("ignored", 10'h302, k);
      if (k == 10) begin
        data_in = 8'h3C; valid_in = 1'b1;
      end else begin
        valid_in = 1'b0;
      end
    end
    for (int i = 0; i < 10; i++) begin
      step();
      idle_check("ignored_after");
    end

    // Reset during data bit 3 abandons the frame.
    data_in = 8'hC3; valid_in = 1'b1;
    step();
    valid_in = 1'b0;
    for (int k = 0; k < 18; k++) begin
      if (k > 0) step();
      frame_check("pre_reset", 10'h386, k);
    end
    rst = 1'b1;
    step();
    rst = 1'b0;
    idle_check("mid_reset");
    repeat (3) begin
      step();
      idle_check("post_reset");
    end
    send_and_check("after_reset", 8'h5A, 10'h2B4);

    // Corner instance: 16 bits, one clock per bit.
    data16 = 16'h8001; valid16 = 1'b1;
    step();
    valid16 = 1'b0;
    begin
      logic [17:0] f16;
      f16 = 18'h30002;
      for (int k = 0; k < 18; k++) begin
        if (k > 0) step();
        check("corner_tx",   tx16,   f16[k]);
        check("corner_busy", busy16, 1'b1);
      end
    end
    step();
    check("corner_end_ready", ready16, 1'b1);
    check("corner_end_busy",  busy16,  1'b0);

    // Random traffic on both instances, occasional reset.
    for (int i = 0; i < 1500; i++) begin
      valid_in = ($urandom_range(0, 2) != 0);
      data_in  = 8'($urandom);
      valid16  = ($urandom_range(0, 3) == 0);
      data16   = 16'($urandom);
      rst      = ($urandom_range(0, 299) == 0);
      step();
    end
    rst = 1'b0; valid_in = 1'b0; valid16 = 1'b0;
    repeat (45) step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
